// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants, types and helpers for the FIFO round-robin arbiter.
// A word's destination FIFO is carried in its top DEST_BITS bits.
package fifo_rr_arbiter_pkg;

  localparam int NUM_FIFOS = 4;
  localparam int WORD_SIZE = 6;
  localparam int DEST_BITS = 2;
  localparam int CNT_BITS  = 8;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [DEST_BITS-1:0] idx_t;
  typedef logic [NUM_FIFOS-1:0] vec_t;

  function automatic idx_t dest_of(input word_t w);
    return w[WORD_SIZE-1 -: DEST_BITS];
  endfunction

  function automatic vec_t onehot(input idx_t idx);
    return vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: the first requester at or after rr_ptr wins.
// Requests are rotated so that offset 0 corresponds to rr_ptr.
module fifo_rr_arbiter_rr_grant
  import fifo_rr_arbiter_pkg::*;
(
  input  vec_t req,
  input  idx_t rr_ptr,
  output idx_t grant,
  output logic grant_valid
);

  vec_t rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_rot
      idx_t idx;
      assign idx         = rr_ptr + idx_t'(gi);
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant       = rr_ptr;
    grant_valid = 1'b0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant       = rr_ptr + idx_t'(k);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Pops input FIFOs round-robin and routes each word to the output FIFO named by
// its destination field; two-stage pipeline, stalls pops on any almost_full.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFOS*WORD_SIZE-1:0] in_data,
  input  logic [NUM_FIFOS-1:0]           in_empty,
  output logic [NUM_FIFOS-1:0]           in_pop,
  input  logic [NUM_FIFOS-1:0]           out_almost_full,
  input  logic [NUM_FIFOS-1:0]           out_full,
  output logic [NUM_FIFOS-1:0]           out_push,
  output logic [WORD_SIZE-1:0]           out_data,
  output logic                           idle,
  output logic                           drop_err,
  output logic [CNT_BITS-1:0]            fwd_count
);

  idx_t  rr_ptr;
  idx_t  sel_q;
  logic  vld_q;
  idx_t  grant;
  logic  grant_valid;
  logic  stall;
  logic  pop_fire;
  word_t words [NUM_FIFOS];
  word_t cur_word;
  idx_t  cur_dest;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_words
      assign words[gi] = in_data[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  fifo_rr_arbiter_rr_grant u_rr_grant (
    .req         (~in_empty),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign stall    = |out_almost_full;
  assign pop_fire = grant_valid & ~stall & ~reset;
  assign in_pop   = pop_fire ? onehot(grant) : '0;

  // The popped FIFO presents its word one cycle after the pop.
  assign cur_word = words[sel_q];
  assign cur_dest = dest_of(cur_word);

  assign idle = (&in_empty) & ~vld_q & ~(|out_push);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      sel_q     <= '0;
      vld_q     <= 1'b0;
      out_push  <= '0;
      out_data  <= '0;
      drop_err  <= 1'b0;
      fwd_count <= '0;
    end else begin
      if (pop_fire) begin
        rr_ptr <= grant + idx_t'(1);
        sel_q  <= grant;
        vld_q  <= 1'b1;
      end else begin
        vld_q  <= 1'b0;
      end

      out_push <= '0;
      if (vld_q) begin
        if (!out_full[cur_dest]) begin
          out_push  <= onehot(cur_dest);
          out_data  <= cur_word;
          fwd_count <= fwd_count + CNT_BITS'(1);
        end else begin
          // Destination full: the word is lost and the error latches until reset.
          drop_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: models the input FIFOs, predicts each
// push when a word is popped and matches it against what the DUT writes out.
module tb_fifo_rr_arbiter;
  import fifo_rr_arbiter_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset = 1'b0;
  logic [NUM_FIFOS*WORD_SIZE-1:0] in_data = '0;
  logic [NUM_FIFOS-1:0]           in_empty = '1;
  logic [NUM_FIFOS-1:0]           in_pop;
  logic [NUM_FIFOS-1:0]           out_almost_full = '0;
  logic [NUM_FIFOS-1:0]           out_full = '0;
  logic [NUM_FIFOS-1:0]           out_push;
  logic [WORD_SIZE-1:0]           out_data;
  logic                           idle;
  logic                           drop_err;
  logic [CNT_BITS-1:0]            fwd_count;

  always #5 clk = ~clk;

  fifo_rr_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_empty        (in_empty),
    .in_pop          (in_pop),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .out_push        (out_push),
    .out_data        (out_data),
    .idle            (idle),
    .drop_err        (drop_err),
    .fwd_count       (fwd_count)
  );

  typedef struct {
    logic [3:0] push;
    logic [5:0] data;
    int         pop_edge;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] fifo_q[NUM_FIFOS][$];
  logic [3:0] pop_log[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_n = 0;
  int         pushes_seen = 0;
  logic [7:0] exp_fwd = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_FIFOS; i++)
      if (fifo_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int idx, input logic [5:0] w);
    fifo_q[idx].push_back(w);
    in_empty[idx] = 1'b0;
  endtask

  // One clock: sample pops, step past the edge, match pushes, advance the FIFO model.
  task automatic tick();
    logic [3:0] pop_s;
    logic [5:0] w;
    logic [1:0] d;
    exp_t       e;
    #1;
    pop_s = in_pop;
    check_eq("pop_onehot0", 32'($onehot0(pop_s)), 32'd1);
    check_eq("pop_of_empty", 32'(pop_s & in_empty), 32'd0);
    if (pop_s != 4'b0) pop_log.push_back(pop_s);
    @(posedge clk);
    #1;
    edge_n++;
    if (out_push != 4'b0) begin
      pushes_seen++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_push", 32'(out_push), 32'd0);
      end else begin
        e = exp_q.pop_front();
        exp_fwd++;
        $display("push edge=%0d vec=%b data=%b", edge_n, out_push, out_data);
        check_eq("push_vec", 32'(out_push), 32'(e.push));
        check_eq("push_data", 32'(out_data), 32'(e.data));
        check_eq("pop_to_push_edges", 32'(edge_n - e.pop_edge), 32'd1);
        check_eq("fwd_count", 32'(fwd_count), 32'(exp_fwd));
      end
    end
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (pop_s[i] && fifo_q[i].size() > 0) begin
        w = fifo_q[i].pop_front();
        in_data[i*WORD_SIZE +: WORD_SIZE] = w;
        d = w[5:4];
        if (!out_full[d]) exp_q.push_back('{push: 4'b0001 << d, data: w, pop_edge: edge_n});
      end
    end
    for (int i = 0; i < NUM_FIFOS; i++) in_empty[i] = (fifo_q[i].size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (idle && all_empty() && exp_q.size() == 0) done = 1'b1;
    end
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap;

    // Reset asserted between clock edges must clear outputs immediately.
    #1 reset = 1'b1;
    #1;
    check_eq("rst_out_push", 32'(out_push), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_fwd_count", 32'(fwd_count), 32'd0);
    check_eq("rst_drop_err", 32'(drop_err), 32'd0);
    check_eq("rst_in_pop", 32'(in_pop), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);

    // Single word from FIFO 1 heading to destination 2.
    load(1, 6'b10_0011);
    #1;
    check_eq("single_pop", 32'(in_pop), 32'b0010);
    tick();
    tick();
    check_eq("single_fwd", 32'(fwd_count), 32'd1);
    drain(10);

    // Round robin: rr_ptr sits at 2 after the single pop from FIFO 1.
    pop_log.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NUM_FIFOS; i++) load(i, 6'((i << 4) | (r << 2) | i));
    drain(40);
    check_eq("rr_pop_count", 32'(pop_log.size()), 32'd12);
    for (int k = 0; k < pop_log.size() && k < 12; k++)
      check_eq("rr_order", 32'(pop_log[k]), 32'(4'b0001 << ((2 + k) % 4)));
    check_eq("rr_fwd", 32'(fwd_count), 32'd13);

    // Back-pressure mid-stream; pointer is back at 2 after twelve pops.
    pop_log.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NUM_FIFOS; i++) load(i, 6'(((3 - i) << 4) | (r << 2) | 2));
    tick();
    tick();
    out_almost_full[2] = 1'b1;
    #1;
    check_eq("stall_pop", 32'(in_pop), 32'd0);
    repeat (3) tick();
    check_eq("stall_no_new_pops", 32'(pop_log.size()), 32'd2);
    check_eq("stall_inflight_done", 32'(exp_q.size()), 32'd0);
    out_almost_full[2] = 1'b0;
    #1;
    check_eq("resume_ptr", 32'(in_pop), 32'b0001);
    drain(40);
    check_eq("bp_fwd", 32'(fwd_count), 32'd25);

    // Drop: destination 3 is full.
    out_full = 4'b1000;
    snap = fwd_count;
    load(0, 6'b11_0101);
    load(1, 6'b01_0010);
    drain(20);
    check_eq("drop_err_set", 32'(drop_err), 32'd1);
    check_eq("drop_fwd", 32'(fwd_count), 32'(snap + 8'd1));
    out_full = 4'b0000;
    repeat (3) tick();
    check_eq("drop_err_sticky", 32'(drop_err), 32'd1);

    // Reset with words in flight: nothing may emerge afterwards.
    load(0, 6'b01_1111);
    load(1, 6'b10_0001);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_out_push", 32'(out_push), 32'd0);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    check_eq("midrst_fwd", 32'(fwd_count), 32'd0);
    check_eq("midrst_drop_err", 32'(drop_err), 32'd0);
    check_eq("midrst_in_pop", 32'(in_pop), 32'd0);
    exp_q.delete();
    exp_fwd = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();
    check_eq("midrst_idle", 32'(idle), 32'd1);

    // Wrap the forwarded-word counter with 256 words.
    pushes_seen = 0;
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < NUM_FIFOS; i++) load(i, 6'($urandom_range(0, 63)));
    drain(400);
    check_eq("wrap_pushes", 32'(pushes_seen), 32'd256);
    check_eq("wrap_fwd", 32'(fwd_count), 32'd0);
    check_eq("wrap_idle", 32'(idle), 32'd1);
    check_eq("wrap_drop_err", 32'(drop_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
